// File: rtl/regfile_debug_arbiter_pkg.sv
// Shared types and constants for the register-file debug arbiter.
package regfile_debug_arbiter_pkg;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 32;

  // Five-stage core: once fetch/decode is frozen, the decode, execute and
  // memory stages may still hold instructions that have to reach writeback.
  localparam int PIPE_STAGES = 5;
  localparam int DRAIN_DEPTH = PIPE_STAGES - 2;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_e;

  // Counter width able to hold (depth - 1), never narrower than one bit.
  function automatic int drain_count_width(input int depth);
    return (depth < 3) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_debug_drain_counter.sv
// Down-counter that sets the pipeline drain hold time before a debug access.
module regfile_debug_drain_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             decrement,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (decrement && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/regfile_debug_arbiter.sv
// Shares the register-file ports between the core and a debug host port.
// Build option: REGFILE_DEBUG_ARBITER_BURST_EN chains queued debug requests without re-draining.
//
// state  | meaning
// RUN    | core owns the register file, no debug activity
// DRAIN  | core front end held, in-flight instructions retire through writeback
// ACCESS | one-cycle debug read/write; core writes blocked
// RESP   | response presented to host, core still held
module regfile_debug_arbiter
  import regfile_debug_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int DRAIN_CYCLES = DRAIN_DEPTH
) (
  input  logic              clock,
  input  logic              reset,

  input  logic [ADDR_W-1:0] core_read_address_1,
  input  logic [ADDR_W-1:0] core_read_address_2,
  input  logic [ADDR_W-1:0] core_write_address,
  input  logic [DATA_W-1:0] core_write_value,
  input  logic              core_write_enable,
  output logic [DATA_W-1:0] core_read_value_1,
  output logic [DATA_W-1:0] core_read_value_2,
  output logic              core_hold,

  output logic [ADDR_W-1:0] rf_read_address_1,
  output logic [ADDR_W-1:0] rf_read_address_2,
  output logic [ADDR_W-1:0] rf_write_address,
  output logic [DATA_W-1:0] rf_write_value,
  output logic              rf_write_enable,
  input  logic [DATA_W-1:0] rf_read_value_1,
  input  logic [DATA_W-1:0] rf_read_value_2,

  input  logic              dbg_req_valid,
  output logic              dbg_req_ready,
  input  logic              dbg_req_write,
  input  logic [ADDR_W-1:0] dbg_req_address,
  input  logic [DATA_W-1:0] dbg_req_wdata,
  output logic              dbg_resp_valid,
  input  logic              dbg_resp_ready,
  output logic [DATA_W-1:0] dbg_resp_rdata
);

  localparam int CNT_W = drain_count_width(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  arb_state_e state;
  arb_state_e state_next;
  logic       drain_load;
  logic       drain_zero;

  regfile_debug_drain_counter #(
    .WIDTH(CNT_W)
  ) u_drain_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (drain_load),
    .load_value (DRAIN_LOAD),
    .decrement  (state == ST_DRAIN),
    .zero       (drain_zero)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    drain_load = 1'b0;
    case (state)
      ST_RUN: begin
        if (dbg_req_valid) begin
          state_next = ST_DRAIN;
          drain_load = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_zero) begin
          state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        state_next = ST_RESP;
      end
      ST_RESP: begin
        if (dbg_resp_ready) begin
`ifdef REGFILE_DEBUG_ARBITER_BURST_EN
          // Pipeline is already empty, so a queued request skips the drain.
          state_next = dbg_req_valid ? ST_ACCESS : ST_RUN;
`else
          state_next = ST_RUN;
`endif
        end
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // Port steering: the core owns every port except during ACCESS.
  always_comb begin
    rf_read_address_1 = core_read_address_1;
    rf_read_address_2 = core_read_address_2;
    rf_write_address  = core_write_address;
    rf_write_value    = core_write_value;
    rf_write_enable   = core_write_enable;
    core_hold         = (state != ST_RUN);
    dbg_req_ready     = 1'b0;
    dbg_resp_valid    = (state == ST_RESP);
    if (state == ST_ACCESS) begin
      rf_read_address_1 = dbg_req_address;
      rf_write_address  = dbg_req_address;
      rf_write_value    = dbg_req_wdata;
      // A reset landing on the access cycle drops the transaction entirely.
      rf_write_enable   = dbg_req_write && !reset;
      dbg_req_ready     = 1'b1;
    end
  end

  assign core_read_value_1 = rf_read_value_1;
  assign core_read_value_2 = rf_read_value_2;

  always_ff @(posedge clock) begin
    if (reset) begin
      dbg_resp_rdata <= '0;
    end else if (state == ST_ACCESS) begin
      dbg_resp_rdata <= dbg_req_write ? '0 : rf_read_value_1;
    end
  end

endmodule

// File: tb/tb_regfile_debug_arbiter.sv
// Scoreboard bench for regfile_debug_arbiter with a behavioural register file.
// Honours REGFILE_DEBUG_ARBITER_BURST_EN for the back-to-back expectations.
module tb_regfile_debug_arbiter;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int DC = 3;

`ifdef REGFILE_DEBUG_ARBITER_BURST_EN
  localparam int EXP_GAP    = 2;
  localparam int EXP_DRAINS = 1;
`else
  localparam int EXP_GAP    = DC + 3;
  localparam int EXP_DRAINS = 3;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] core_read_address_1, core_read_address_2, core_write_address;
  logic [DW-1:0] core_write_value;
  logic          core_write_enable;
  logic [DW-1:0] core_read_value_1, core_read_value_2;
  logic          core_hold;
  logic [AW-1:0] rf_read_address_1, rf_read_address_2, rf_write_address;
  logic [DW-1:0] rf_write_value;
  logic          rf_write_enable;
  logic [DW-1:0] rf_read_value_1, rf_read_value_2;
  logic          dbg_req_valid, dbg_req_ready, dbg_req_write;
  logic [AW-1:0] dbg_req_address;
  logic [DW-1:0] dbg_req_wdata;
  logic          dbg_resp_valid, dbg_resp_ready;
  logic [DW-1:0] dbg_resp_rdata;

  int compared = 0;
  int mismatched = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_v;

  logic [DW-1:0] regs [64];
  logic          clear_regs;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (clear_regs) begin
      for (int i = 0; i < 64; i++) regs[i] <= '0;
    end else if (rf_write_enable) begin
      regs[rf_write_address] <= rf_write_value;
    end
  end

  assign rf_read_value_1 = regs[rf_read_address_1];
  assign rf_read_value_2 = regs[rf_read_address_2];

  regfile_debug_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DRAIN_CYCLES(DC)) dut (
    .clock(clock), .reset(reset),
    .core_read_address_1(core_read_address_1), .core_read_address_2(core_read_address_2),
    .core_write_address(core_write_address), .core_write_value(core_write_value),
    .core_write_enable(core_write_enable),
    .core_read_value_1(core_read_value_1), .core_read_value_2(core_read_value_2),
    .core_hold(core_hold),
    .rf_read_address_1(rf_read_address_1), .rf_read_address_2(rf_read_address_2),
    .rf_write_address(rf_write_address), .rf_write_value(rf_write_value),
    .rf_write_enable(rf_write_enable),
    .rf_read_value_1(rf_read_value_1), .rf_read_value_2(rf_read_value_2),
    .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
    .dbg_req_write(dbg_req_write), .dbg_req_address(dbg_req_address),
    .dbg_req_wdata(dbg_req_wdata), .dbg_resp_valid(dbg_resp_valid),
    .dbg_resp_ready(dbg_resp_ready), .dbg_resp_rdata(dbg_resp_rdata)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    core_read_address_1 = '0;
    core_read_address_2 = '0;
    core_write_address  = '0;
    core_write_value    = '0;
    core_write_enable   = 1'b0;
    dbg_req_valid       = 1'b0;
    dbg_req_write       = 1'b0;
    dbg_req_address     = '0;
    dbg_req_wdata       = '0;
    dbg_resp_ready      = 1'b0;
  endtask

  // Drives one complete debug transaction and reports what was observed.
  task automatic run_txn(
    input  logic          wr,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    input  logic          core_we_access,
    input  logic          inflight,
    input  logic [AW-1:0] if_addr,
    input  logic [DW-1:0] if_val,
    output int            ready_lat,
    output int            resp_lat,
    output logic [DW-1:0] rdata,
    output logic          hold_t0,
    output logic          hold_t1,
    output logic          acc_we,
    output logic [AW-1:0] acc_waddr,
    output logic [DW-1:0] acc_wval,
    output logic          timeout
  );
    int cnt;
    timeout = 1'b0;
    rdata = '0;
    acc_we = 1'b0;
    acc_waddr = '0;
    acc_wval = '0;
    resp_lat = 0;
    dbg_req_valid = 1'b1;
    dbg_req_write = wr;
    dbg_req_address = addr;
    dbg_req_wdata = wdata;
    #1;
    hold_t0 = core_hold;
    tick();
    cnt = 1;
    hold_t1 = core_hold;
    if (inflight) begin
      core_write_address = if_addr;
      core_write_value = if_val;
      core_write_enable = 1'b1;
    end
    while (!dbg_req_ready && cnt < 50) begin
      tick();
      cnt++;
      core_write_enable = 1'b0;
    end
    ready_lat = cnt;
    if (!dbg_req_ready) begin
      timeout = 1'b1;
      idle_inputs();
      return;
    end
    if (core_we_access) begin
      core_write_address = 6'd9;
      core_write_value = 32'h00000BAD;
      core_write_enable = 1'b1;
      #1;
    end
    acc_we = rf_write_enable;
    acc_waddr = rf_write_address;
    acc_wval = rf_write_value;
    tick();
    core_write_enable = 1'b0;
    dbg_req_valid = 1'b0;
    cnt = 1;
    while (!dbg_resp_valid && cnt < 50) begin
      tick();
      cnt++;
    end
    resp_lat = cnt;
    if (!dbg_resp_valid) begin
      timeout = 1'b1;
      idle_inputs();
      return;
    end
    rdata = dbg_resp_rdata;
    dbg_resp_ready = 1'b1;
    tick();
    dbg_resp_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    clear_regs = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    clear_regs = 1'b0;
    #1;
    compared++;
    if (core_hold !== 1'b0) begin
      mismatched++; $display("FAIL reset_hold got=%b exp=0", core_hold);
    end
    compared++;
    if (dbg_req_ready !== 1'b0 || dbg_resp_valid !== 1'b0) begin
      mismatched++; $display("FAIL reset_handshake ready=%b resp_valid=%b exp=0/0", dbg_req_ready, dbg_resp_valid);
    end
    compared++;
    if (dbg_resp_rdata !== '0) begin
      mismatched++; $display("FAIL reset_rdata got=%h exp=0", dbg_resp_rdata);
    end
  endtask

  task automatic test_passthrough();
    core_write_address = 6'd5;
    core_write_value = 32'h1234;
    core_write_enable = 1'b1;
    core_read_address_1 = 6'd2;
    core_read_address_2 = 6'd9;
    #1;
    compared++;
    if (rf_write_enable !== 1'b1 || rf_write_address !== 6'd5 || rf_write_value !== 32'h1234) begin
      mismatched++; $display("FAIL pass_write got=%b/%0d/%h exp=1/5/00001234", rf_write_enable, rf_write_address, rf_write_value);
    end
    compared++;
    if (rf_read_address_1 !== 6'd2 || rf_read_address_2 !== 6'd9 || core_hold !== 1'b0) begin
      mismatched++; $display("FAIL pass_read_addr got=%0d/%0d hold=%b exp=2/9/0", rf_read_address_1, rf_read_address_2, core_hold);
    end
    tick();
    core_write_enable = 1'b0;
    core_read_address_1 = 6'd5;
    core_read_address_2 = 6'd0;
    #1;
    compared++;
    if (core_read_value_1 !== 32'h1234 || core_read_value_2 !== 32'h0) begin
      mismatched++; $display("FAIL pass_read_value got=%h/%h exp=00001234/00000000", core_read_value_1, core_read_value_2);
    end
  endtask

  task automatic test_debug_read();
    int rl, pl;
    logic [DW-1:0] rd;
    logic h0, h1, awe, to;
    logic [AW-1:0] awa;
    logic [DW-1:0] awv;
    exp_q.push_back(32'h00001234);
    run_txn(1'b0, 6'd5, '0, 1'b0, 1'b0, '0, '0, rl, pl, rd, h0, h1, awe, awa, awv, to);
    compared++;
    if (to) begin
      mismatched++; $display("FAIL read_timeout got=timeout exp=response");
    end
    compared++;
    if (h0 !== 1'b0 || h1 !== 1'b1) begin
      mismatched++; $display("FAIL read_hold_rise got=%b%b exp=01", h0, h1);
    end
    compared++;
    if (rl !== DC + 1 || pl !== 1) begin
      mismatched++; $display("FAIL read_latency got=%0d/%0d exp=%0d/1", rl, pl, DC + 1);
    end
    exp_v = exp_q.pop_front();
    compared++;
    if (rd !== exp_v) begin
      mismatched++; $display("FAIL read_rdata got=%h exp=%h", rd, exp_v);
    end
    compared++;
    if (core_hold !== 1'b0 || dbg_resp_valid !== 1'b0) begin
      mismatched++; $display("FAIL read_release hold=%b resp_valid=%b exp=0/0", core_hold, dbg_resp_valid);
    end
  endtask

  task automatic test_write_then_read();
    int rl, pl;
    logic [DW-1:0] rd;
    logic h0, h1, awe, to;
    logic [AW-1:0] awa;
    logic [DW-1:0] awv;
    core_write_address = 6'd9;
    core_write_value = 32'h99;
    core_write_enable = 1'b1;
    tick();
    core_write_enable = 1'b0;
    exp_q.push_back(32'h0);
    run_txn(1'b1, 6'd7, 32'hDEADBEEF, 1'b1, 1'b0, '0, '0, rl, pl, rd, h0, h1, awe, awa, awv, to);
    exp_v = exp_q.pop_front();
    compared++;
    if (to || rd !== exp_v) begin
      mismatched++; $display("FAIL write_rdata got=%h timeout=%b exp=%h", rd, to, exp_v);
    end
    compared++;
    if (awe !== 1'b1 || awa !== 6'd7 || awv !== 32'hDEADBEEF) begin
      mismatched++; $display("FAIL write_access_port got=%b/%0d/%h exp=1/7/deadbeef", awe, awa, awv);
    end
    exp_q.push_back(32'hDEADBEEF);
    run_txn(1'b0, 6'd7, '0, 1'b1, 1'b0, '0, '0, rl, pl, rd, h0, h1, awe, awa, awv, to);
    exp_v = exp_q.pop_front();
    compared++;
    if (to || rd !== exp_v) begin
      mismatched++; $display("FAIL raw_rdata got=%h timeout=%b exp=%h", rd, to, exp_v);
    end
    compared++;
    if (awe !== 1'b0) begin
      mismatched++; $display("FAIL read_access_blocks_core got=%b exp=0", awe);
    end
    core_read_address_1 = 6'd9;
    #1;
    compared++;
    if (core_read_value_1 !== 32'h99) begin
      mismatched++; $display("FAIL core_write_blocked got=%h exp=00000099", core_read_value_1);
    end
  endtask

  task automatic test_inflight();
    int rl, pl;
    logic [DW-1:0] rd;
    logic h0, h1, awe, to;
    logic [AW-1:0] awa;
    logic [DW-1:0] awv;
    exp_q.push_back(32'h5555);
    run_txn(1'b0, 6'd3, '0, 1'b0, 1'b1, 6'd3, 32'h5555, rl, pl, rd, h0, h1, awe, awa, awv, to);
    exp_v = exp_q.pop_front();
    compared++;
    if (to || rd !== exp_v) begin
      mismatched++; $display("FAIL inflight_rdata got=%h timeout=%b exp=%h", rd, to, exp_v);
    end
  endtask

  task automatic test_reset_midflight();
    int cnt;
    logic seen;
    dbg_req_valid = 1'b1;
    dbg_req_write = 1'b1;
    dbg_req_address = 6'd11;
    dbg_req_wdata = 32'h77;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    dbg_req_valid = 1'b0;
    #1;
    compared++;
    if (core_hold !== 1'b0 || dbg_resp_valid !== 1'b0 || dbg_req_ready !== 1'b0) begin
      mismatched++; $display("FAIL reset_in_drain hold=%b resp_valid=%b ready=%b exp=0/0/0", core_hold, dbg_resp_valid, dbg_req_ready);
    end
    seen = 1'b0;
    for (int i = 0; i < DC + 4; i++) begin
      if (dbg_req_ready || dbg_resp_valid || rf_write_enable) seen = 1'b1;
      tick();
    end
    core_read_address_1 = 6'd11;
    #1;
    compared++;
    if (seen !== 1'b0 || core_read_value_1 !== 32'h0) begin
      mismatched++; $display("FAIL reset_drain_dropped activity=%b r11=%h exp=0/00000000", seen, core_read_value_1);
    end
    dbg_req_write = 1'b0;
    dbg_req_address = 6'd5;
    dbg_req_valid = 1'b1;
    cnt = 0;
    while (!dbg_req_ready && cnt < 50) begin
      tick();
      cnt++;
    end
    tick();
    dbg_req_valid = 1'b0;
    #1;
    compared++;
    if (dbg_resp_valid !== 1'b1 || dbg_resp_rdata !== 32'h1234) begin
      mismatched++; $display("FAIL reach_resp resp_valid=%b rdata=%h exp=1/00001234", dbg_resp_valid, dbg_resp_rdata);
    end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    compared++;
    if (core_hold !== 1'b0 || dbg_resp_valid !== 1'b0 || dbg_resp_rdata !== '0) begin
      mismatched++; $display("FAIL reset_in_resp hold=%b resp_valid=%b rdata=%h exp=0/0/0", core_hold, dbg_resp_valid, dbg_resp_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs [3];
    logic [DW-1:0] vals [3];
    int times [3];
    int idx, got, cyc, rises;
    logic adv, prev_hold;
    addrs[0] = 6'd5; vals[0] = 32'h1234;
    addrs[1] = 6'd7; vals[1] = 32'hDEADBEEF;
    addrs[2] = 6'd3; vals[2] = 32'h5555;
    idx = 0; got = 0; cyc = 0; rises = 0;
    dbg_req_write = 1'b0;
    dbg_req_address = addrs[0];
    dbg_req_valid = 1'b1;
    dbg_resp_ready = 1'b1;
    exp_q.push_back(vals[0]);
    #1;
    prev_hold = core_hold;
    while (got < 3 && cyc < 200) begin
      adv = dbg_req_ready;
      if (dbg_resp_valid) begin
        exp_v = exp_q.pop_front();
        compared++;
        if (dbg_resp_rdata !== exp_v) begin
          mismatched++; $display("FAIL b2b_rdata[%0d] got=%h exp=%h", got, dbg_resp_rdata, exp_v);
        end
        times[got] = cyc;
        got++;
      end
      if (core_hold && !prev_hold) rises++;
      prev_hold = core_hold;
      tick();
      cyc++;
      if (adv) begin
        idx++;
        if (idx < 3) begin
          dbg_req_address = addrs[idx];
          exp_q.push_back(vals[idx]);
        end else begin
          dbg_req_valid = 1'b0;
        end
      end
      #1;
    end
    dbg_resp_ready = 1'b0;
    dbg_req_valid = 1'b0;
    compared++;
    if (got !== 3) begin
      mismatched++; $display("FAIL b2b_count got=%0d exp=3", got);
    end else begin
      compared++;
      if (times[1] - times[0] !== EXP_GAP || times[2] - times[1] !== EXP_GAP) begin
        mismatched++; $display("FAIL b2b_gap got=%0d/%0d exp=%0d", times[1] - times[0], times[2] - times[1], EXP_GAP);
      end
    end
    compared++;
    if (rises !== EXP_DRAINS) begin
      mismatched++; $display("FAIL b2b_drains got=%0d exp=%0d", rises, EXP_DRAINS);
    end
    tick();
  endtask

  initial begin
    reset = 1'b1;
    clear_regs = 1'b1;
    idle_inputs();
    test_reset();
    test_passthrough();
    test_debug_read();
    test_write_then_read();
    test_inflight();
    test_reset_midflight();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
